// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected datapath
// (MAC accumulator and the downstream requantization stage).
package fc_pkg;

    localparam int ACC_W  = 32;
    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } fc_mac_state_t;

    // Requantization constants, imported by the int8 requant stage.
    localparam logic signed [31:0] REQ_MULT       = 32'sd1073741824;
    localparam int                 REQ_SHIFT      = 8;
    localparam logic signed [7:0]  REQ_ZERO_POINT = 8'sd0;

    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/fc_mul_stage.sv
// Registered signed 8x8->16 multiplier with valid pass-through and
// synchronous clear.
module fc_mul_stage
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] act,
    input  logic signed [DATA_W-1:0] wgt,
    output logic signed [PROD_W-1:0] prod,
    output logic                     prod_valid
);

    always_ff @(posedge clk) begin
        if (clr) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            if (in_valid)
                prod <= act * wgt;
        end
    end

endmodule

// File: rtl/fc_mac_accum.sv
// FC multiply-accumulate: bias + sum(act*wgt) over IN_LEN beats, result
// presented on a valid/ready output.
module fc_mac_accum
    import fc_pkg::*;
#(
    parameter int IN_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] wgt_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy
);

    localparam int              CNT_W     = $clog2(IN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_LEN - 1);

    fc_mac_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              beat;

    assign in_ready  = (state == ACCUM);
    assign acc_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && (state == ACCUM);
    assign acc_sum   = acc + (prod_valid ? sext_prod(prod) : '0);

    fc_mul_stage u_mul (
        .clk        (clk),
        .clr        (rst),
        .in_valid   (beat),
        .act        (act_in),
        .wgt        (wgt_in),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (beat && cnt == LAST_BEAT) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc_out is only loaded leaving DRAIN so it holds through IDLE
    // while acc is reloaded with the next bias.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            acc_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= bias;
                    cnt <= '0;
                end
                ACCUM: begin
                    acc <= acc_sum;
                    if (beat) cnt <= cnt + 1'b1;
                end
                DRAIN: begin
                    acc     <= acc_sum;
                    acc_out <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_mac_accum.sv
// Bench for fc_mac_accum: IN_LEN=4 instance for table vectors and
// corner sequences, IN_LEN=1 instance for single-beat latency and wrap.
module tb_fc_mac_accum;
    import fc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start4, start1, in_valid, acc_ready;
    logic [31:0] bias;
    logic [7:0]  act, wgt;
    logic        in_ready4, acc_valid4, busy4;
    logic        in_ready1, acc_valid1, busy1;
    logic [31:0] acc_out4, acc_out1;

    int checks = 0;
    int errors = 0;
    logic [31:0] q4[$];
    logic [31:0] q1[$];

    typedef struct {
        logic [31:0] bias;
        logic [7:0]  act[4];
        logic [7:0]  wgt[4];
        int          bub;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    fc_mac_accum #(.IN_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready4), .act_in(act), .wgt_in(wgt),
        .acc_out(acc_out4), .acc_valid(acc_valid4), .acc_ready(acc_ready),
        .busy(busy4)
    );

    fc_mac_accum #(.IN_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready1), .act_in(act), .wgt_in(wgt),
        .acc_out(acc_out1), .acc_valid(acc_valid1), .acc_ready(acc_ready),
        .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: pop an expected result on every output handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && acc_valid4 && acc_ready) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb4 unexpected result %h", acc_out4);
            end else chk("sb4_result", acc_out4, q4.pop_front());
        end
        if (!rst && acc_valid1 && acc_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1 unexpected result %h", acc_out1);
            end else chk("sb1_result", acc_out1, q1.pop_front());
        end
    end

    task automatic run4(input vec_t v, input int hold);
        @(negedge clk);
        bias = v.bias; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("accum_busy", {31'b0, busy4}, 32'd1);
        chk("accum_in_ready", {31'b0, in_ready4}, 32'd1);
        q4.push_back(v.exp);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; act = v.act[i]; wgt = v.wgt[i];
            @(negedge clk);
            if (i < 3)
                for (int b = 0; b < v.bub; b++) begin
                    in_valid = 1'b0; act = 8'($urandom); wgt = 8'($urandom);
                    @(negedge clk);
                end
        end
        // Cycle T+1 (DRAIN): junk offered on in_valid must be ignored.
        in_valid = 1'b1; act = 8'h55; wgt = 8'h55;
        chk("drain_acc_valid", {31'b0, acc_valid4}, 32'd0);
        chk("drain_in_ready", {31'b0, in_ready4}, 32'd0);
        @(negedge clk);
        chk("t2_acc_valid", {31'b0, acc_valid4}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            start4 = (h == 2);
            chk("bp_acc_out", acc_out4, v.exp);
            chk("bp_acc_valid", {31'b0, acc_valid4}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready4}, 32'd0);
            @(negedge clk);
        end
        acc_ready = 1'b1;
        start4 = (hold > 0);
        @(negedge clk);
        acc_ready = 1'b0; start4 = 1'b0; in_valid = 1'b0;
        chk("post_hs_acc_valid", {31'b0, acc_valid4}, 32'd0);
        chk("post_hs_busy", {31'b0, busy4}, 32'd0);
        chk("idle_hold_acc_out", acc_out4, v.exp);
    endtask

    task automatic run1(input logic [31:0] b, input logic [7:0] a, input logic [7:0] w,
                        input logic [31:0] exp);
        @(negedge clk);
        bias = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; in_valid = 1'b1; act = a; wgt = w;
        q1.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        chk("len1_c2_acc_valid", {31'b0, acc_valid1}, 32'd0);
        @(negedge clk);
        chk("len1_c3_acc_valid", {31'b0, acc_valid1}, 32'd1);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("len1_idle_busy", {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        tbl[0].bias = 32'd100;
        tbl[0].act = '{8'd1, 8'd2, 8'd3, 8'd4};
        tbl[0].wgt = '{8'd5, 8'd6, 8'd7, 8'd8};
        tbl[0].bub = 0; tbl[0].exp = 32'h0000_00AA;
        tbl[1].bias = 32'd0;
        tbl[1].act = '{8'h80, 8'h80, 8'h80, 8'h80};
        tbl[1].wgt = '{8'h80, 8'h80, 8'h80, 8'h80};
        tbl[1].bub = 0; tbl[1].exp = 32'h0001_0000;
        tbl[2].bias = 32'd0;
        tbl[2].act = '{8'h80, 8'h80, 8'h80, 8'h80};
        tbl[2].wgt = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        tbl[2].bub = 0; tbl[2].exp = 32'hFFFF_0200;
        tbl[3] = tbl[0];
        tbl[3].bub = 2;
        tbl[4].bias = 32'hFFFF_FC18;
        tbl[4].act = '{8'hFF, 8'hFE, 8'h03, 8'h7F};
        tbl[4].wgt = '{8'h0A, 8'hEC, 8'h1E, 8'hFF};
        tbl[4].bub = 1; tbl[4].exp = 32'hFFFF_FC11;

        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; in_valid = 1'b0;
        acc_ready = 1'b0; bias = '0; act = '0; wgt = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready4}, 32'd0);
        chk("rst_acc_valid", {31'b0, acc_valid4}, 32'd0);
        chk("rst_acc_out", acc_out4, 32'd0);
        chk("rst_busy", {31'b0, busy4}, 32'd0);
        chk("rst_acc_out1", acc_out1, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++)
            run4(tbl[k], 0);

        // Back-pressure with an ignored start pulse in OUT and in the handshake cycle.
        run4(tbl[0], 5);

        // Single-beat instance: latency and modulo-2^32 wrap in both directions.
        run1(32'h7FFF_FFFF, 8'd1, 8'd1, 32'h8000_0000);
        run1(32'h8000_0000, 8'h80, 8'h7F, 32'h7FFF_C080);

        // Reset after 2 of 4 beats; stale product must not leak into the next sum.
        @(negedge clk);
        bias = 32'd100; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        in_valid = 1'b1; act = 8'd1; wgt = 8'd5;
        @(negedge clk);
        act = 8'd2; wgt = 8'd6;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", {31'b0, in_ready4}, 32'd0);
        chk("mid_rst_acc_valid", {31'b0, acc_valid4}, 32'd0);
        chk("mid_rst_acc_out", acc_out4, 32'd0);
        chk("mid_rst_busy", {31'b0, busy4}, 32'd0);
        run4(tbl[0], 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", q4.size() + q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
